// File: rtl/hdmi_period_sync.sv
// HDMI receive-side period sequencer: tracks control/preamble/guard/video/island
// periods, qualifies pixels, recovers syncs and frames island packets.
module hdmi_period_sync #(
  parameter int PREAMBLE_LEN = 8,
  parameter int MAX_PACKETS  = 18
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [5:0]  i_kind,
  input  logic [5:0]  i_ctl,
  input  logic [11:0] i_aux,
  input  logic [23:0] i_pix,
  output logic        o_pix_valid,
  output logic [23:0] o_pix,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_island_valid,
  output logic        o_island_start,
  output logic [11:0] o_island_data,
  output logic        o_err
);

  localparam int PW = $clog2(PREAMBLE_LEN + 1);
  localparam int KW = $clog2(MAX_PACKETS + 2);

  typedef enum logic [2:0] {
    S_CTRL, S_VPRE, S_VGUARD, S_VIDEO, S_DPRE, S_DGUARD, S_ISLAND, S_TGUARD
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  pre_q, pre_d;
  logic [4:0]     chr_q, chr_d;
  logic [KW-1:0]  pkt_q, pkt_d;
  logic           tg2_q, tg2_d;
  logic           pv_q, pv_d, iv_q, iv_d, is_q, is_d, err_q, err_d;
  logic           hs_q, hs_d, vs_q, vs_d;
  logic [23:0]    pix_q, pix_d;
  logic [11:0]    idata_q, idata_d;

  logic [1:0] k0, k1, k2;
  logic all_ctrl, all_video, all_terc4, vid_pre, isl_pre, vguard, iguard;
  logic pre_full, ctrl_entry;

  assign k0 = i_kind[1:0];
  assign k1 = i_kind[3:2];
  assign k2 = i_kind[5:4];
  assign all_ctrl  = (k0 == 2'd1) && (k1 == 2'd1) && (k2 == 2'd1);
  assign all_video = (k0 == 2'd0) && (k1 == 2'd0) && (k2 == 2'd0);
  assign all_terc4 = (k0 == 2'd2) && (k1 == 2'd2) && (k2 == 2'd2);
  assign vid_pre   = all_ctrl && (i_ctl[3:2] == 2'b01) && (i_ctl[5:4] == 2'b00);
  assign isl_pre   = all_ctrl && (i_ctl[3:2] == 2'b01) && (i_ctl[5:4] == 2'b01);
  assign vguard    = (k0 == 2'd3) && (k1 == 2'd3) && (k2 == 2'd3);
  assign iguard    = (k0 == 2'd2) && (k1 == 2'd3) && (k2 == 2'd3);
  assign pre_full  = (pre_q >= PW'(PREAMBLE_LEN));

  // Next-state, counter and output decode for the current character.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    chr_d   = chr_q;
    pkt_d   = pkt_q;
    tg2_d   = tg2_q;
    pv_d    = 1'b0;
    pix_d   = 24'd0;
    iv_d    = 1'b0;
    is_d    = 1'b0;
    idata_d = 12'd0;
    err_d   = 1'b0;
    hs_d    = hs_q;
    vs_d    = vs_q;
    ctrl_entry = 1'b0;
    case (state_q)
      S_CTRL: ctrl_entry = 1'b1;
      S_VPRE: begin
        if (vid_pre) pre_d = pre_full ? pre_q : pre_q + PW'(1);
        else if (all_ctrl) begin state_d = S_CTRL; pre_d = '0; end
        else if (vguard && pre_full) state_d = S_VGUARD;
        else err_d = 1'b1;
      end
      S_DPRE: begin
        if (isl_pre) pre_d = pre_full ? pre_q : pre_q + PW'(1);
        else if (all_ctrl) begin state_d = S_CTRL; pre_d = '0; end
        else if (iguard && pre_full) state_d = S_DGUARD;
        else err_d = 1'b1;
      end
      S_VGUARD: begin
        if (vguard) state_d = S_VIDEO;
        else err_d = 1'b1;
      end
      S_VIDEO: begin
        if (all_video) begin pv_d = 1'b1; pix_d = i_pix; end
        else if (all_ctrl) ctrl_entry = 1'b1;
        else err_d = 1'b1;
      end
      S_DGUARD: begin
        if (iguard) begin state_d = S_ISLAND; chr_d = 5'd0; pkt_d = '0; end
        else err_d = 1'b1;
      end
      S_ISLAND: begin
        // The last character of packet MAX_PACKETS+1 would push the count over.
        if (all_terc4 && !(chr_q == 5'd31 && pkt_q == KW'(MAX_PACKETS))) begin
          iv_d    = 1'b1;
          is_d    = (chr_q == 5'd0);
          idata_d = i_aux;
          chr_d   = chr_q + 5'd1;
          pkt_d   = (chr_q == 5'd31) ? pkt_q + KW'(1) : pkt_q;
        end else if (iguard && chr_q == 5'd0 && pkt_q != '0) begin
          state_d = S_TGUARD;
          tg2_d   = 1'b0;
        end else err_d = 1'b1;
      end
      S_TGUARD: begin
        if (!tg2_q) begin
          if (iguard) tg2_d = 1'b1;
          else err_d = 1'b1;
        end else if (all_ctrl) ctrl_entry = 1'b1;
        else err_d = 1'b1;
      end
      default: state_d = S_CTRL;
    endcase
    if (ctrl_entry) begin
      if (vid_pre) begin state_d = S_VPRE; pre_d = PW'(1); end
      else if (isl_pre) begin state_d = S_DPRE; pre_d = PW'(1); end
      else begin state_d = S_CTRL; pre_d = '0; end
    end else begin
      pre_d = pre_d;
    end
    if (err_d) begin
      state_d = S_CTRL;
      pre_d   = '0;
      chr_d   = 5'd0;
      pkt_d   = '0;
      tg2_d   = 1'b0;
    end else begin
      tg2_d = tg2_d;
    end
    if (k0 == 2'd1) begin hs_d = i_ctl[0]; vs_d = i_ctl[1]; end
    else if (k0 == 2'd2) begin hs_d = i_aux[0]; vs_d = i_aux[1]; end
    else begin hs_d = hs_q; vs_d = vs_q; end
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= S_CTRL;
      pre_q   <= '0;
      chr_q   <= 5'd0;
      pkt_q   <= '0;
      tg2_q   <= 1'b0;
      pv_q    <= 1'b0;
      pix_q   <= 24'd0;
      iv_q    <= 1'b0;
      is_q    <= 1'b0;
      idata_q <= 12'd0;
      err_q   <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      chr_q   <= chr_d;
      pkt_q   <= pkt_d;
      tg2_q   <= tg2_d;
      pv_q    <= pv_d;
      pix_q   <= pix_d;
      iv_q    <= iv_d;
      is_q    <= is_d;
      idata_q <= idata_d;
      err_q   <= err_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
    end
  end

  assign o_pix_valid    = pv_q;
  assign o_pix          = pix_q;
  assign o_hsync        = hs_q;
  assign o_vsync        = vs_q;
  assign o_island_valid = iv_q;
  assign o_island_start = is_q;
  assign o_island_data  = idata_q;
  assign o_err          = err_q;

endmodule

// File: tb/tb_hdmi_period_sync.sv
// Self-checking bench for hdmi_period_sync: each scenario builds a character
// stream with expected flags derived from the period rules, then drives and checks it.
module tb_hdmi_period_sync;

  localparam int PL = 8;
  localparam int MP = 18;

  typedef struct packed {
    logic [5:0]  k;
    logic [5:0]  c;
    logic [11:0] a;
    logic [23:0] p;
    logic        pv, iv, is, err;
  } ch_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  kind = 6'd0, ctl = 6'd0;
  logic [11:0] aux = 12'd0;
  logic [23:0] pix = 24'd0;
  logic        pv_o, hs_o, vs_o, iv_o, is_o, err_o;
  logic [23:0] pix_o;
  logic [11:0] idata_o;

  int tests = 0;
  int failed = 0;
  logic m_hs = 1'b0, m_vs = 1'b0;

  hdmi_period_sync #(.PREAMBLE_LEN(PL), .MAX_PACKETS(MP)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_kind(kind), .i_ctl(ctl), .i_aux(aux),
    .i_pix(pix), .o_pix_valid(pv_o), .o_pix(pix_o), .o_hsync(hs_o),
    .o_vsync(vs_o), .o_island_valid(iv_o), .o_island_start(is_o),
    .o_island_data(idata_o), .o_err(err_o)
  );

  always #5 clk = ~clk;

  function automatic ch_t mk(logic [5:0] k, logic pv, logic iv, logic is, logic err);
    ch_t c;
    c.k = k; c.c = 6'($urandom()); c.a = 12'($urandom()); c.p = 24'($urandom());
    c.pv = pv; c.iv = iv; c.is = is; c.err = err;
    return c;
  endfunction

  // typ: 0 idle control, 1 video preamble, 2 island preamble
  function automatic ch_t mk_ctrl(int typ, logic err);
    ch_t c;
    int r;
    c = mk(6'b010101, 1'b0, 1'b0, 1'b0, err);
    r = $urandom_range(0, 2);
    if (typ == 1) c.c[5:2] = 4'b0001;
    else if (typ == 2) c.c[5:2] = 4'b0101;
    else c.c[3:2] = (r == 0) ? 2'b00 : ((r == 1) ? 2'b10 : 2'b11);
    return c;
  endfunction

  function automatic ch_t mk_vguard(logic err);
    return mk(6'b111111, 1'b0, 1'b0, 1'b0, err);
  endfunction

  function automatic ch_t mk_iguard(logic err);
    return mk(6'b111110, 1'b0, 1'b0, 1'b0, err);
  endfunction

  // Drive one character, sample 1 ns after the edge, and form the expected outputs.
  task automatic drive_one(input ch_t c, input logic rst, output logic [41:0] obs,
                           output logic [41:0] exp);
    kind = c.k; ctl = c.c; aux = c.a; pix = c.p; rst_n = ~rst;
    if (rst) begin m_hs = 1'b0; m_vs = 1'b0; end
    else if (c.k[1:0] == 2'd1) begin m_hs = c.c[0]; m_vs = c.c[1]; end
    else if (c.k[1:0] == 2'd2) begin m_hs = c.a[0]; m_vs = c.a[1]; end
    @(posedge clk);
    #1;
    obs = {pv_o, pix_o, iv_o, is_o, idata_o, hs_o, vs_o, err_o};
    if (rst) exp = 42'd0;
    else exp = {c.pv, c.pv ? c.p : 24'd0, c.iv, c.is, c.iv ? c.a : 12'd0, m_hs, m_vs, c.err};
  endtask

  task automatic test_reset();
    logic [41:0] obs, exp;
    for (int i = 0; i < 3; i++) begin
      drive_one(mk(6'($urandom()), 1'b0, 1'b0, 1'b0, 1'b0), 1'b1, obs, exp);
      tests++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL reset cyc %0d: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_video(int npre, int ng, int npix, int bad_at, bit fixed);
    ch_t q[$];
    logic [41:0] obs, exp;
    bit stop;
    ch_t c;
    q.push_back(mk_ctrl(0, 1'b0));
    for (int i = 0; i < npre; i++) q.push_back(mk_ctrl(1, 1'b0));
    if (npre < PL) q.push_back(mk_vguard(1'b1));
    else if (ng == 1) begin
      q.push_back(mk_vguard(1'b0));
      q.push_back(mk(6'b000000, 1'b0, 1'b0, 1'b0, 1'b1));
    end else if (ng == 3) begin
      q.push_back(mk_vguard(1'b0));
      q.push_back(mk_vguard(1'b0));
      q.push_back(mk_vguard(1'b1));
    end else begin
      q.push_back(mk_vguard(1'b0));
      q.push_back(mk_vguard(1'b0));
      stop = 1'b0;
      for (int j = 0; j < npix && !stop; j++) begin
        if (j == bad_at) begin
          q.push_back(mk(6'b000100, 1'b0, 1'b0, 1'b0, 1'b1));
          stop = 1'b1;
        end else begin
          c = mk(6'b000000, 1'b1, 1'b0, 1'b0, 1'b0);
          if (fixed) c.p = 24'h112233 + 24'(j) * 24'h111111;
          q.push_back(c);
        end
      end
    end
    q.push_back(mk_ctrl(0, 1'b0));
    q.push_back(mk_ctrl(0, 1'b0));
    for (int i = 0; i < q.size(); i++) begin
      drive_one(q[i], 1'b0, obs, exp);
      tests++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL video(pre=%0d g=%0d n=%0d bad=%0d) char %0d: got %h expected %h",
                 npre, ng, npix, bad_at, i, obs, exp);
      end
    end
  endtask

  task automatic test_island(int npre, int npk, int bad_at, int ntrail);
    ch_t q[$];
    logic [41:0] obs, exp;
    bit stop;
    stop = 1'b0;
    q.push_back(mk_ctrl(0, 1'b0));
    for (int i = 0; i < npre; i++) q.push_back(mk_ctrl(2, 1'b0));
    if (npre < PL) begin
      q.push_back(mk_iguard(1'b1));
      stop = 1'b1;
    end else begin
      q.push_back(mk_iguard(1'b0));
      q.push_back(mk_iguard(1'b0));
    end
    for (int j = 0; j < npk * 32 && !stop; j++) begin
      if (j == bad_at) begin
        q.push_back(mk_iguard(1'b1));
        stop = 1'b1;
      end else if (j % 32 == 31 && j / 32 == MP) begin
        q.push_back(mk(6'b101010, 1'b0, 1'b0, 1'b0, 1'b1));
        stop = 1'b1;
      end else q.push_back(mk(6'b101010, 1'b0, 1'b1, (j % 32) == 0, 1'b0));
    end
    if (!stop) begin
      if (npk == 0) q.push_back(mk_iguard(1'b1));
      else if (ntrail == 1) begin
        q.push_back(mk_iguard(1'b0));
        q.push_back(mk_ctrl(0, 1'b1));
      end else begin
        q.push_back(mk_iguard(1'b0));
        q.push_back(mk_iguard(1'b0));
        if (ntrail == 3) q.push_back(mk_iguard(1'b1));
      end
    end
    q.push_back(mk_ctrl(0, 1'b0));
    q.push_back(mk_ctrl(0, 1'b0));
    for (int i = 0; i < q.size(); i++) begin
      drive_one(q[i], 1'b0, obs, exp);
      tests++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL island(pre=%0d pk=%0d bad=%0d tr=%0d) char %0d: got %h expected %h",
                 npre, npk, bad_at, ntrail, i, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    ch_t q[$];
    bit rst[$];
    ch_t c;
    logic [41:0] obs, exp;
    for (int i = 0; i < PL; i++) begin q.push_back(mk_ctrl(1, 1'b0)); rst.push_back(1'b0); end
    for (int i = 0; i < 2; i++) begin q.push_back(mk_vguard(1'b0)); rst.push_back(1'b0); end
    for (int i = 0; i < 2; i++) begin
      q.push_back(mk(6'b000000, 1'b1, 1'b0, 1'b0, 1'b0)); rst.push_back(1'b0);
    end
    q.push_back(mk(6'b000000, 1'b0, 1'b0, 1'b0, 1'b0)); rst.push_back(1'b1);
    c = mk_ctrl(0, 1'b0);
    c.c[1:0] = 2'b00;
    q.push_back(c); rst.push_back(1'b0);
    for (int i = 0; i < q.size(); i++) begin
      drive_one(q[i], rst[i], obs, exp);
      tests++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL reset_mid char %0d: got %h expected %h", i, obs, exp);
      end
    end
    test_video(PL, 2, 4, -1, 1'b0);
  endtask

  task automatic test_random();
    int ng, bad, npk, tr;
    for (int n = 0; n < 40; n++) begin
      ng = ($urandom_range(0, 4) == 0) ? (($urandom_range(0, 1) == 0) ? 1 : 3) : 2;
      tr = ($urandom_range(0, 4) == 0) ? (($urandom_range(0, 1) == 0) ? 1 : 3) : 2;
      if ($urandom_range(0, 1) == 0) begin
        bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
        test_video($urandom_range(5, 12), ng, $urandom_range(1, 6), bad, 1'b0);
      end else begin
        npk = $urandom_range(0, 3);
        bad = -1;
        if (npk > 0 && $urandom_range(0, 3) == 0) begin
          bad = $urandom_range(0, npk * 32 - 1);
          if (bad % 32 == 0 && bad != 0) bad = bad + 1;
        end
        test_island($urandom_range(5, 12), npk, bad, tr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_video(PL, 2, 4, -1, 1'b1);
    test_video(PL - 1, 2, 4, -1, 1'b0);
    test_video(PL, 2, 4, -1, 1'b1);
    test_island(PL, 2, -1, 2);
    test_island(PL, 2, 17, 2);
    test_video(PL, 3, 4, -1, 1'b0);
    test_video(PL + 3, 1, 4, -1, 1'b0);
    test_island(PL, 1, 0, 2);
    test_island(PL, 0, -1, 2);
    test_island(PL, 1, -1, 3);
    test_island(PL, 1, -1, 1);
    test_island(PL, MP, -1, 2);
    test_island(PL, MP + 1, -1, 2);
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
